logic_op_fifo: RTL and testbench



---
 rtl/logic_op_fifo.sv | 134 +++++++++++++
 tb/tb_logic_op_fifo.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/logic_op_fifo.sv
// logic_op_fifo
//   Registered bitwise logic unit with a DEPTH-entry output FIFO.
//   Each accepted operand pair is reduced by one of eight bitwise functions.
//   The result is queued together with its zero flag. Operand A may instead
//   come from an accumulator that always holds the most recent result.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand pair presented
//   in_ready   block can accept (FIFO not full)
//   a, b       operands (WIDTH bits)
//   op         operation select (3 bits)
//   acc_mode   take operand A from the accumulator
//   acc_clr    clear the accumulator (zero operand A when it coincides with a transfer)
//   out_valid  FIFO head valid (FIFO not empty)
//   out_ready  consumer takes head
//   out_data   FIFO head result
//   out_zero   FIFO head result is zero
//   level      FIFO occupancy
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. The producer must hold its payload stable until that edge.
// Ready never depends on valid on the same port. While the FIFO is full,
// a pop does not open a slot for a push in the same cycle.

module logic_op_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           a,
  input  logic [WIDTH-1:0]           b,
  input  logic [2:0]                 op,
  input  logic                       acc_mode,
  input  logic                       acc_clr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_zero,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem   [DEPTH];
  logic             zflag [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [LW-1:0]    cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] result;
  logic             push;
  logic             pop;

  assign in_ready  = (cnt != LW'(DEPTH));
  assign out_valid = (cnt != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign level     = cnt;
  assign out_data  = mem[rd_ptr];
  assign out_zero  = zflag[rd_ptr];

  // A clear that coincides with an accumulate transfer zeroes the operand.
  // The stored accumulator then takes the new result.
  always_comb begin
    op_a = a;
    if (acc_mode) begin
      op_a = acc_clr ? '0 : acc;
    end
  end

  always_comb begin
    result = '0;
    case (op)
      3'b000:  result = op_a & b;
      3'b001:  result = op_a | b;
      3'b010:  result = ~op_a | ~b;
      3'b011:  result = ~(op_a | b);
      3'b100:  result = op_a ^ b;
      3'b101:  result = ~(op_a ^ b);
      3'b110:  result = ~op_a;
      3'b111:  result = op_a & ~b;
      default: result = '0;
    endcase
  end

  // Storage is reset as well, so the head never reads X after reset.
  // A zero head reports out_zero=1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i]   <= '0;
        zflag[i] <= 1'b1;
      end
    end else if (push) begin
      mem[wr_ptr]   <= result;
      zflag[wr_ptr] <= (result == '0);
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + LW'(1);
        2'b01:   cnt <= cnt - LW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (push) begin
      acc <= result;
    end else if (acc_clr) begin
      acc <= '0;
    end
  end

endmodule

// File: tb/tb_logic_op_fifo.sv
// tb_logic_op_fifo
//   Directed bench for logic_op_fifo at WIDTH=4, DEPTH=4.
//   Inputs change on the falling edge, and outputs are sampled on the falling
//   edge after each rising edge. A small scoreboard tracks the queue contents,
//   the occupancy and the accumulator. Directed phases also check the results
//   against values worked out by hand.

module tb_logic_op_fifo;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic [2:0]       op = '0;
  logic             acc_mode = 1'b0;
  logic             acc_clr = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic             out_zero;
  logic [LW-1:0]    level;

  logic_op_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .acc_mode  (acc_mode),
    .acc_clr   (acc_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_zero  (out_zero),
    .level     (level)
  );

  // ---------------- scoreboard ----------------
  logic [WIDTH:0]   exp_q[$];   // {zero, data}
  logic [WIDTH-1:0] m_acc = '0;
  int               n_cmp = 0;
  int               n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] model_op(input logic [2:0] o,
                                                input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
    case (o)
      3'd0:    return x & y;
      3'd1:    return x | y;
      3'd2:    return ~(x & y);
      3'd3:    return ~x & ~y;
      3'd4:    return x ^ y;
      3'd5:    return x ^ ~y;
      3'd6:    return ~x;
      default: return x & ~y;
    endcase
  endfunction

  // ---------------- driver ----------------
  // Advance one cycle with the current inputs. Then check every output
  // against the model.
  task automatic step();
    bit               push, pop;
    logic [WIDTH-1:0] ea, r;
    push = in_valid && (exp_q.size() != DEPTH);
    pop  = (exp_q.size() != 0) && out_ready;
    ea   = acc_mode ? (acc_clr ? '0 : m_acc) : a;
    r    = model_op(op, ea, b);
    @(posedge clk);
    @(negedge clk);
    if (pop)  void'(exp_q.pop_front());
    if (push) exp_q.push_back({(r == '0), r});
    if (push)         m_acc = r;
    else if (acc_clr) m_acc = '0;
    check("level", 32'(level), 32'(exp_q.size()));
    check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    check("in_ready", 32'(in_ready), 32'(exp_q.size() != DEPTH));
    if (exp_q.size() != 0) begin
      check("head_data", 32'(out_data), 32'(exp_q[0][WIDTH-1:0]));
      check("head_zero", 32'(out_zero), 32'(exp_q[0][WIDTH]));
    end
    check("no_x", 32'($isunknown({out_data, out_zero, out_valid, in_ready, level})), 32'd0);
  endtask

  task automatic drive(input logic v, input logic [3:0] av, input logic [3:0] bv,
                       input logic [2:0] o, input logic am, input logic ac, input logic rdy);
    in_valid = v; a = av; b = bv; op = o; acc_mode = am; acc_clr = ac; out_ready = rdy;
  endtask

  task automatic drain();
    drive(1'b0, 4'h0, 4'h0, 3'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH + 1; i++) step();
  endtask

  logic [3:0] ops_exp [8] = '{4'b1000, 4'b1110, 4'b0111, 4'b0001,
                              4'b0110, 4'b1001, 4'b0011, 4'b0100};
  logic [3:0] acc_exp [4] = '{4'b0001, 4'b0011, 4'b0111, 4'b0000};
  logic [3:0] acc_b   [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b0111};

  initial begin
    // ---- reset ----
    #12;
    check("rst_level", 32'(level), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_zero", 32'(out_zero), 32'd1);
    check("rst_out_data", 32'(out_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // ---- all ops, a=1100 b=1010, streaming ----
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 4'b1100, 4'b1010, 3'(i), 1'b0, 1'b0, 1'b1);
      step();
      check($sformatf("op%0d_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("op%0d_data", i), 32'(out_data), 32'(ops_exp[i]));
    end
    drain();

    // ---- accumulate chain ----
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 4'b1111, acc_b[i], (i == 3) ? 3'd4 : 3'd1, 1'b1, (i == 0), 1'b1);
      step();
      check($sformatf("acc%0d_data", i), 32'(out_data), 32'(acc_exp[i]));
    end
    check("acc_zero_flag", 32'(out_zero), 32'd1);
    drain();

    // ---- full / back-pressure: push 1..5 with AND 1111 ----
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 4'(i), 4'hf, 3'd0, 1'b0, 1'b0, 1'b0);
      step();
    end
    check("full_level", 32'(level), 32'd4);
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_head", 32'(out_data), 32'd1);
    out_ready = 1'b1;             // pop while full: the 5th must not enter
    step();
    check("pop_full_level", 32'(level), 32'd3);
    out_ready = 1'b0;             // 5th accepted now
    step();
    check("refill_level", 32'(level), 32'd4);
    drive(1'b0, 4'h0, 4'h0, 3'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 2; i <= 5; i++) begin
      check($sformatf("order%0d", i), 32'(out_data), 32'(i));
      step();
    end
    check("drained", 32'(out_valid), 32'd0);

    // ---- concurrent push/pop at level 2 ----
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 4'(i + 9), 4'hf, 3'd0, 1'b0, 1'b0, 1'b0);
      step();
    end
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 4'(i * 3 + 1), 4'hf, 3'd0, 1'b0, 1'b0, 1'b1);
      step();
      check("conc_level", 32'(level), 32'd2);
    end
    drain();

    // ---- random ----
    for (int i = 0; i < 1000; i++) begin
      drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
      step();
    end
    drain();

    // ---- asynchronous reset mid-clock with 3 buffered ----
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'(i + 5), 4'hf, 3'd0, 1'b0, 1'b0, 1'b0);
      step();
    end
    check("pre_rst_level", 32'(level), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_level", 32'(level), 32'd0);
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    check("arst_out_zero", 32'(out_zero), 32'd1);
    exp_q.delete();
    m_acc = '0;
    drive(1'b0, 4'h0, 4'h0, 3'd0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    // Accumulator must have been cleared: acc | 0 = 0.
    drive(1'b1, 4'hf, 4'h0, 3'd1, 1'b1, 1'b0, 1'b1);
    step();
    check("post_rst_acc", 32'(out_data), 32'd0);
    check("post_rst_zero", 32'(out_zero), 32'd1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
